// File: rtl/uop_issue_seq.sv
// rtl/uop_issue_seq.sv - in-order uop buffer with flag-dependency issue gating
package uop_issue_seq_pkg;
  typedef enum logic [1:0] {
    UPD_NONE  = 2'd0,
    UPD_ADD   = 2'd1,
    UPD_LOGIC = 2'd2,
    UPD_ALL   = 2'd3
  } upd_pat_e;

  typedef struct packed {
    logic [7:0] op;
    logic       flgdep;
    upd_pat_e   updpat;
  } uop_t;
endpackage

module uop_issue_seq
  import uop_issue_seq_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int PENDMAX = 7
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [2:0]               in_cnt_i,
  input  uop_t [3:0]               in_uop_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output uop_t                     out_uop_o,
  input  logic                     flg_done_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [2:0]               pend_o,
  output logic                     err_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [2:0]    PEND_LIM = 3'(PENDMAX);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] GROUP_C  = CW'(4);

  uop_t          mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [2:0]    pend;
  logic          err;

  uop_t          head;
  logic          accept;
  logic          cnt_ok;
  logic [2:0]    wr_cnt;
  logic          pop;
  logic          pend_inc;
  logic          pend_dec;
  logic          dep_block;
  logic          lim_block;

  // Issue/accept handshakes and the per-cycle write count.
  always_comb begin
    head        = mem[rd_ptr];
    in_ready_o  = rst_ni && !flush_i && ((DEPTH_C - count) >= GROUP_C);
    accept      = in_valid_i && in_ready_o;
    cnt_ok      = (in_cnt_i <= 3'd4);
    wr_cnt      = (accept && cnt_ok) ? in_cnt_i : 3'd0;
    dep_block   = head.flgdep && (pend != 3'd0);
    lim_block   = (head.updpat != UPD_NONE) && (pend == PEND_LIM);
    out_valid_o = rst_ni && (count != '0) && !flush_i && !dep_block && !lim_block;
    pop         = out_valid_o && out_ready_i;
    pend_inc    = pop && (head.updpat != UPD_NONE);
    pend_dec    = flg_done_i;
    out_uop_o   = head;
    count_o     = count;
    pend_o      = pend;
    err_o       = err;
  end

  // Buffer storage: slots 0..wr_cnt-1 land at consecutive wrapped addresses.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < wr_cnt) begin
        mem[wr_ptr + AW'(i)] <= in_uop_i[i];
      end
    end
  end

  // Pointers and occupancy; flush empties the buffer and drops same-cycle traffic.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_cnt);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + CW'(wr_cnt) - CW'(pop);
    end
  end

  // Outstanding flag writers survive flush: already-issued uops still complete.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend <= 3'd0;
    end else if (pend_inc && !pend_dec) begin
      pend <= pend + 3'd1;
    end else if (pend_dec && !pend_inc && (pend != 3'd0)) begin
      pend <= pend - 3'd1;
    end
  end

  // Sticky error: bad group size or a completion with nothing outstanding.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err <= 1'b0;
    end else if ((accept && !cnt_ok) || (pend_dec && !pend_inc && (pend == 3'd0))) begin
      err <= 1'b1;
    end
  end
endmodule

// File: doc/uop_issue_seq.md
UOP_ISSUE_SEQ -- requirements
Module: rf68000ooo_uop_issue_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning uop buffer entries (power of two).
REQ-002 SHALL have parameter PENDMAX, default 7, meaning max outstanding flag-writing uops.
REQ-003 SHALL have port clk_i, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port flush_i, input, 1, meaning discard all buffered uops.
REQ-006 SHALL have port in_valid_i, input, 1, meaning a decoded uop group is offered.
REQ-007 SHALL have port in_ready_o, output, 1, meaning the group will be accepted this cycle.
REQ-008 SHALL have port in_cnt_i, input, 3, meaning uops in the group (0..4).
REQ-009 SHALL have port in_uop_i, input, 4 x uop_t, meaning the group; slot 0 is oldest.
REQ-010 SHALL have port out_valid_o, output, 1, meaning head uop is issuable.
REQ-011 SHALL have port out_ready_i, input, 1, meaning the consumer takes the uop.
REQ-012 SHALL have port out_uop_o, output, uop_t, meaning the head uop.
REQ-013 SHALL have port flg_done_i, input, 1, meaning one flag-writing uop has completed.
REQ-014 SHALL have port count_o, output, log2(DEPTH)+1, meaning buffer occupancy.
REQ-015 SHALL have port pend_o, output, 3, meaning outstanding flag writers.
REQ-016 SHALL have port err_o, output, 1, meaning sticky protocol error.

Function
REQ-017 SHALL store uops in a circular FIFO with wrapping read/write pointers mod DEPTH.
REQ-018 SHALL drive in_ready_o = !flush_i && (DEPTH - count) >= 4, independent of in_cnt_i.
REQ-019 SHALL, on in_valid_i && in_ready_o, write slots 0..in_cnt_i-1 in order and advance the write pointer by in_cnt_i.
REQ-020 SHALL, when in_cnt_i = 0 or in_cnt_i > 4 is accepted, write nothing; values > 4 set err_o.
REQ-021 SHALL drive out_uop_o combinationally from the head entry, including when out_valid_o is low.
REQ-022 SHALL drive out_valid_o = !empty && !flush_i && !(head.flgdep && pend != 0) && !(head.updpat != UPD_NONE && pend == PENDMAX).
REQ-023 SHALL pop the head on out_valid_o && out_ready_i; at most one uop issues per cycle.
REQ-024 SHALL increment pend when the issued uop has updpat != UPD_NONE, and decrement it on flg_done_i.
REQ-025 SHALL leave pend unchanged when an increment and a decrement occur in the same cycle.
REQ-026 SHALL hold pend at 0 on flg_done_i when pend = 0, and set err_o.
REQ-027 SHALL keep err_o set until reset.
REQ-028 SHALL allow write and pop in the same cycle; count_next = count + accepted_cnt - pop.
REQ-029 SHALL, on flush_i, set both pointers and count to 0 on the next edge and ignore same-cycle writes and pops.
REQ-030 SHALL NOT change pend on flush_i; issued uops still complete.
REQ-031 SHALL require that out_uop_o and out_valid_o remain stable while out_valid_o && !out_ready_i, unless flush_i is asserted.

Reset
REQ-032 SHALL, while rst_ni = 0, force pointers, count_o, pend_o and err_o to 0.
REQ-033 SHALL force in_ready_o and out_valid_o low while rst_ni = 0.
REQ-034 SHALL discard any operation in progress on reset assertion.
REQ-035 SHALL leave buffer contents undefined after reset.
REQ-036 SHALL accept input on the first rising edge after rst_ni deasserts.

Verification
REQ-037 SHALL cover: reset, push a group of cnt=3 (updpat NONE, flgdep 0) with out_ready_i=1 -> issue in order over 3 cycles, count_o 3->2->1->0.
REQ-038 SHALL cover: issue an UPD_ADD uop, then a flgdep=1 uop -> pend_o=1, out_valid_o low until flg_done_i, issue the cycle after pend_o returns to 0.
REQ-039 SHALL cover: occupancy 5 of 8 -> in_ready_o=0; pop 1 -> in_ready_o=1; push cnt=4 -> count_o=8 with pointer wrap, and order preserved.
REQ-040 SHALL cover: pend=7 with head updpat=UPD_LOGIC -> out_valid_o=0; same-cycle issue plus flg_done_i at pend=3 -> pend stays 3.
REQ-041 SHALL cover: flush_i with 6 buffered uops and pend=2 -> count_o=0 next cycle, pend_o still 2.
REQ-042 SHALL cover: flg_done_i at pend=0 -> err_o=1, pend_o=0, and err_o clears only on rst_ni low mid-stream.
